// File: rtl/operand_entry_fsm_if.sv
// Switch/key inputs and registered adder-operand outputs of the operand entry front end.
interface operand_entry_fsm_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] sw_data;
    logic             sw_cin;
    logic             key_enter_n;
    logic             key_clear_n;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_out;
    logic             result_valid;
    logic [1:0]       state_code;

    modport master (
        output sw_data, sw_cin, key_enter_n, key_clear_n,
        input  op_a, op_b, cin_out, result_valid, state_code
    );

    modport slave (
        input  sw_data, sw_cin, key_enter_n, key_clear_n,
        output op_a, op_b, cin_out, result_valid, state_code
    );
endinterface

// File: rtl/operand_entry_fsm.sv
// Debounced two-key operand entry: captures A, then B and carry-in, and holds them for the adder.
module operand_entry_fsm #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    operand_entry_fsm_if.slave bus
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SHOW   = 2'd2
    } state_t;

    // Bit 0 is the enter key, bit 1 the clear key.
    logic [1:0]       key_raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       prev;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt [2];
    logic             enter_ev;
    logic             clear_ev;

    state_t           state;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             cin_q;
    logic             valid_q;

    assign key_raw = {bus.key_clear_n, bus.key_enter_n};

    // Synchronize, then accept a new level only after it has been stable for DEBOUNCE_CYCLES.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            prev  <= '1;
            for (int k = 0; k < 2; k++) cnt[k] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            prev  <= deb;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    deb[k] <= sync2[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign press    = prev & ~deb;
    assign enter_ev = press[0];
    assign clear_ev = press[1];

    // Entry sequencer; clear wins over enter, and the unused encoding recovers to LOAD_A.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state   <= LOAD_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cin_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (clear_ev) begin
            state   <= LOAD_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cin_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (enter_ev) begin
                        op_a_q <= bus.sw_data;
                        state  <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (enter_ev) begin
                        op_b_q  <= bus.sw_data;
                        cin_q   <= bus.sw_cin;
                        valid_q <= 1'b1;
                        state   <= SHOW;
                    end
                end
                SHOW: begin
                    if (enter_ev) begin
                        op_a_q  <= bus.sw_data;
                        op_b_q  <= '0;
                        cin_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state   <= LOAD_B;
                    end
                end
                default: begin
                    state   <= LOAD_A;
                    op_a_q  <= '0;
                    op_b_q  <= '0;
                    cin_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.cin_out      = cin_q;
    assign bus.result_valid = valid_q;
    assign bus.state_code   = state;
endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with DEBOUNCE_CYCLES=4 (key events land on edge 7).
module tb_operand_entry_fsm;
    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    operand_entry_fsm_if #(.WIDTH(4)) bus ();

    operand_entry_fsm #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) u_dut (
        .CLOCK_50 (clk),
        .Resetn   (rst_n),
        .bus      (bus)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the selected keys low for 'hold' cycles, then release and let the debouncer settle.
    task automatic press(input bit ent, input bit clr, input int hold);
        bus.key_enter_n = ~ent;
        bus.key_clear_n = ~clr;
        step(hold);
        bus.key_enter_n = 1'b1;
        bus.key_clear_n = 1'b1;
        step(10);
    endtask

    task automatic check_all(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic c, input logic v, input logic [1:0] s);
        check_val({tag, "_op_a"}, 32'(bus.op_a), 32'(a));
        check_val({tag, "_op_b"}, 32'(bus.op_b), 32'(b));
        check_val({tag, "_cin"}, 32'(bus.cin_out), 32'(c));
        check_val({tag, "_valid"}, 32'(bus.result_valid), 32'(v));
        check_val({tag, "_state"}, 32'(bus.state_code), 32'(s));
    endtask

    logic [4:0] sum;

    initial begin
        bus.sw_data     = 4'd0;
        bus.sw_cin      = 1'b0;
        bus.key_enter_n = 1'b1;
        bus.key_clear_n = 1'b1;

        // 1. Asynchronous reset with the clock stopped
        #3 rst_n = 1'b0;
        #1 check_all("rst_async", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
        clk_en = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(3);
        check_all("rst_hold", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);

        // 2. Normal entry with exact latency
        bus.sw_data     = 4'd7;
        bus.key_enter_n = 1'b0;
        step(6);
        check_val("lat_edge6_op_a", 32'(bus.op_a), 32'd0);
        check_val("lat_edge6_state", 32'(bus.state_code), 32'd0);
        step(1);
        check_val("lat_edge7_op_a", 32'(bus.op_a), 32'd7);
        check_val("lat_edge7_state", 32'(bus.state_code), 32'd1);
        step(3);
        bus.key_enter_n = 1'b1;
        step(10);
        check_val("release_no_event", 32'(bus.state_code), 32'd1);
        bus.sw_data = 4'd9;
        bus.sw_cin  = 1'b1;
        press(1'b1, 1'b0, 10);
        check_all("entry_b", 4'd7, 4'd9, 1'b1, 1'b1, 2'd2);
        sum = 5'(bus.op_a) + 5'(bus.op_b) + 5'(bus.cin_out);
        check_val("sum_7_9_1", 32'(sum), 32'h11);

        // 3. Bounce rejection from SHOW, then one capture on a solid hold
        bus.sw_data = 4'd5;
        for (int i = 0; i < 5; i++) begin
            bus.key_enter_n = 1'b0;
            step(2);
            bus.key_enter_n = 1'b1;
            step(2);
        end
        step(6);
        check_all("bounce", 4'd7, 4'd9, 1'b1, 1'b1, 2'd2);
        press(1'b1, 1'b0, 20);
        check_all("bounce_hold", 4'd5, 4'd0, 1'b0, 1'b0, 2'd1);

        // 4. Long hold in LOAD_B with switches toggling every cycle
        bus.sw_cin      = 1'b0;
        bus.key_enter_n = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            bus.sw_data = 4'(i);
            step(1);
            if (i == 100) check_val("hold_mid_op_b", 32'(bus.op_b), 32'd6);
        end
        bus.key_enter_n = 1'b1;
        step(10);
        check_all("hold_end", 4'd5, 4'd6, 1'b0, 1'b1, 2'd2);

        // 5a. Clear and enter together in LOAD_B: clear wins
        bus.sw_data = 4'hA;
        press(1'b1, 1'b0, 10);
        check_val("pre_prio_op_a", 32'(bus.op_a), 32'hA);
        check_val("pre_prio_state", 32'(bus.state_code), 32'd1);
        bus.sw_data = 4'h4;
        press(1'b1, 1'b1, 10);
        check_all("prio", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);

        // 5b. Maximum operands, then re-entry straight from SHOW
        bus.sw_data = 4'hF;
        bus.sw_cin  = 1'b1;
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 10);
        check_all("max", 4'hF, 4'hF, 1'b1, 1'b1, 2'd2);
        sum = 5'(bus.op_a) + 5'(bus.op_b) + 5'(bus.cin_out);
        check_val("sum_max", 32'(sum), 32'd31);
        bus.sw_data = 4'd3;
        press(1'b1, 1'b0, 10);
        check_all("reentry", 4'd3, 4'd0, 1'b0, 1'b0, 2'd1);

        // 6. Reset during a debounce; the held key must restart from scratch
        bus.sw_data     = 4'hC;
        bus.key_enter_n = 1'b0;
        step(3);
        rst_n = 1'b0;
        #1 check_all("mid_rst", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
        step(1);
        rst_n = 1'b1;
        step(6);
        check_val("post_rst_edge6_op_a", 32'(bus.op_a), 32'd0);
        check_val("post_rst_edge6_state", 32'(bus.state_code), 32'd0);
        step(1);
        check_val("post_rst_edge7_op_a", 32'(bus.op_a), 32'hC);
        check_val("post_rst_edge7_state", 32'(bus.state_code), 32'd1);
        bus.key_enter_n = 1'b1;
        step(10);
        press(1'b0, 1'b1, 10);
        check_all("final_clear", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Sequential front end for the 4-bit adder/display lab datapath.
- Captures two operands and a carry-in from the switches using debounced pushbutton presses.
- Holds them stable on outputs that drive the combinational adder directly. The adder's sum then feeds the two-digit seven-segment decoder.
- Flags when a complete operand set is loaded so the result shown on the display is meaningful.

Parameters:
- WIDTH, 4, operand width in bits.
- DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles needed before a synchronized key level is accepted (10 ms at 50 MHz). Benches override this to 4.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous active-low reset.
- sw_data  input  WIDTH  operand value from switches.
- sw_cin  input  1  carry-in switch.
- key_enter_n  input  1  enter pushbutton, active-low, asynchronous to the clock.
- key_clear_n  input  1  clear pushbutton, active-low, asynchronous to the clock.
- op_a  output  WIDTH  operand A to the adder.
- op_b  output  WIDTH  operand B to the adder.
- cin_out  output  1  carry-in to the adder.
- result_valid  output  1  high while both operands are loaded.
- state_code  output  2  current state for LEDs: 0=LOAD_A, 1=LOAD_B, 2=SHOW.

Behaviour:
- Reset, asynchronous on Resetn=0:
  - op_a=0, op_b=0, cin_out=0, result_valid=0, state LOAD_A (state_code=0).
  - Synchronizer flops, debounced levels and previous-level flops all set to 1 (released).
  - Debounce counters set to 0.
  - Reset takes effect immediately, without a clock edge, in any state.
- Input conditioning, per key, identical logic for both:
  - 2-flop synchronizer.
  - Counter increments each cycle the synchronized level differs from the debounced level. It clears to 0 on any cycle they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synchronized value and the counter clears.
  - Press event is a 1-cycle pulse asserted in the cycle after the debounced level goes 1->0.
  - Release produces no event.
  - Any low pulse shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
  - A key held low for any duration yields exactly one event.
- Latency: count the first clock edge that samples the key pin low as edge 1. The debounced level falls at edge DEBOUNCE_CYCLES+2, and registered outputs update at edge DEBOUNCE_CYCLES+3 (edge 7 for DEBOUNCE_CYCLES=4).
- FSM, evaluated on each clock edge, with a clear event taking priority over an enter event:
  - Clear event in any state: op_a=0, op_b=0, cin_out=0, result_valid=0, go to LOAD_A.
  - LOAD_A + enter: op_a<=sw_data, go to LOAD_B.
  - LOAD_B + enter: op_b<=sw_data, cin_out<=sw_cin, result_valid<=1, go to SHOW.
  - SHOW + enter: op_a<=sw_data, op_b<=0, cin_out<=0, result_valid<=0, go to LOAD_B. This starts a new entry without requiring a clear.
  - No event: all registers hold.
- Data capture:
  - sw_data and sw_cin are sampled only on the event cycle.
  - Switch changes at any other time have no effect on outputs.
  - Switches are treated as quasi-static and are not synchronized.
- Outputs are registered and glitch-free; there is no combinational path from inputs to outputs.
- Arithmetic: none inside the block. The downstream adder computes op_a+op_b+cin_out with a WIDTH+1-bit result. The maximum 15+15+1=31 must be representable by the display stage.
- Unused state encoding 3: next state is LOAD_A with outputs cleared, same as a clear event.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset:
   - Stimulus: assert Resetn=0 mid-cycle with no clock.
   - Response: op_a=0, op_b=0, cin_out=0, result_valid=0, state_code=0 immediately. Values hold after release.
2. Normal entry:
   - Stimulus: sw_data=7, press enter for 10 cycles, release. Then sw_data=9, sw_cin=1, press enter.
   - Response: op_a=7 at edge 7 after the first press, state_code=1. Then op_b=9, cin_out=1, result_valid=1, state_code=2.
   - Downstream sum: 17 (0x11).
3. Bounce rejection:
   - Stimulus: key_enter_n pulses low for 2 cycles, 5 times, with 2 high cycles between. Then held low for 20 cycles.
   - Response: no capture during the bounces. Exactly one capture during the hold.
4. Held key and switch isolation:
   - Stimulus: in LOAD_B, hold enter low for 1000 cycles while toggling sw_data each cycle.
   - Response: one transition to SHOW. op_b equals the sw_data value present on the event cycle. It is not updated afterward.
5. Priority and re-entry:
   - Stimulus (a): clear and enter events in the same cycle in LOAD_B.
   - Response (a): LOAD_A, all outputs 0.
   - Stimulus (b): from SHOW (op_a=15, op_b=15, cin=1), press enter with sw_data=3.
   - Response (b): op_a=3, op_b=0, cin_out=0, result_valid=0, state_code=1.
6. Reset mid-debounce:
   - Stimulus: assert Resetn for 1 cycle while enter has been low for 3 cycles, keep enter low, then release reset.
   - Response: no capture from the pre-reset press. Capture occurs DEBOUNCE_CYCLES+3 edges after reset release, counted from the first post-reset edge that samples the pin low.
